// File: rtl/sum_capture_fifo.sv
// Result-capture FIFO behind the ripple-carry adder: stores {co, s} words with a valid/ready handshake.
// Optional output-toggle accounting is enabled by defining SUM_CAPTURE_TOGGLE_CNT_EN.
module sum_capture_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TCW   = 16
) (
  input  logic                       clk,
  input  logic                       reset_L,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_s,
  input  logic                       in_co,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [WIDTH:0]             out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic [TCW-1:0]             toggle_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned DW = WIDTH + 1;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [DW-1:0] out_data_q, out_data_d;
  logic [DW-1:0] in_word;
  logic          push, pop;

  assign in_word   = {in_co, in_s};
  assign in_ready  = (count_q != CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign count     = count_q;
  assign out_data  = out_data_q;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    mem_d      = mem_q;
    out_data_d = out_data_q;

    if (push) begin
      mem_d[wr_ptr_q] = in_word;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // out_data is a register so it can keep the last popped word once empty;
    // when the next head is the slot being written this cycle, take the incoming word.
    if (count_d != '0) begin
      if (push && (wr_ptr_q == rd_ptr_d)) begin
        out_data_d = in_word;
      end else begin
        out_data_d = mem_q[rd_ptr_d];
      end
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (!reset_L) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      out_data_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      out_data_q <= out_data_d;
    end
  end

`ifdef SUM_CAPTURE_TOGGLE_CNT_EN
  localparam int unsigned SW = TCW + $clog2(DW + 1);

  logic [DW-1:0]  last_word_q, last_word_d;
  logic [TCW-1:0] toggle_cnt_q, toggle_cnt_d;
  logic [DW-1:0]  diff;
  logic [SW-1:0]  pc, sum;

  assign diff       = in_word ^ last_word_q;
  assign toggle_cnt = toggle_cnt_q;

  always_comb begin
    last_word_d  = last_word_q;
    toggle_cnt_d = toggle_cnt_q;
    pc           = '0;
    for (int unsigned i = 0; i < DW; i++) begin
      pc = pc + SW'(diff[i]);
    end
    sum = SW'(toggle_cnt_q) + pc;
    if (push) begin
      last_word_d  = in_word;
      toggle_cnt_d = (sum > SW'({TCW{1'b1}})) ? '1 : sum[TCW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      last_word_q  <= '0;
      toggle_cnt_q <= '0;
    end else begin
      last_word_q  <= last_word_d;
      toggle_cnt_q <= toggle_cnt_d;
    end
  end
`else
  assign toggle_cnt = '0;
`endif

endmodule

// File: tb/tb_sum_capture_fifo.sv
// Directed bench for sum_capture_fifo: queue-based reference model checked every cycle, plus literal spot checks.
module tb_sum_capture_fifo;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned TCW   = 4;

  logic             clk = 1'b0;
  logic             reset_L = 1'b0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_s = '0;
  logic             in_co = 1'b0;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH:0]   out_data;
  logic             out_ready = 1'b0;
  logic [2:0]       count;
  logic [TCW-1:0]   toggle_cnt;

  int tests = 0;
  int fails = 0;

  sum_capture_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TCW(TCW)) dut (
    .clk(clk), .reset_L(reset_L), .in_valid(in_valid), .in_s(in_s), .in_co(in_co),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .count(count), .toggle_cnt(toggle_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int tog_exp(input int v);
`ifdef SUM_CAPTURE_TOGGLE_CNT_EN
    return v;
`else
    return 0;
`endif
  endfunction

  // Reference model: a queue of words, the last popped word and a saturating toggle sum.
  logic [WIDTH:0] mq[$];
  logic [WIDTH:0] m_last_pop;
  logic [WIDTH:0] m_last_word;
  int             m_tog;
  bit             model_ok = 1'b0;

  always @(posedge clk) begin
    logic [WIDTH:0] w;
    bit pu, po;
    if (!reset_L) begin
      mq.delete();
      m_last_pop  = '0;
      m_last_word = '0;
      m_tog       = 0;
      model_ok    = 1'b1;
    end else begin
      w  = {in_co, in_s};
      pu = in_valid && (mq.size() < DEPTH);
      po = out_ready && (mq.size() > 0);
      if (po) m_last_pop = mq.pop_front();
      if (pu) begin
        mq.push_back(w);
        m_tog = m_tog + $countones(w ^ m_last_word);
        if (m_tog > (1 << TCW) - 1) m_tog = (1 << TCW) - 1;
        m_last_word = w;
      end
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      chk("m_count", 32'(count), 32'(mq.size()));
      chk("m_out_valid", 32'(out_valid), 32'(mq.size() != 0));
      chk("m_in_ready", 32'(in_ready), 32'(mq.size() != DEPTH));
      chk("m_out_data", 32'(out_data), 32'((mq.size() != 0) ? mq[0] : m_last_pop));
      chk("m_toggle", 32'(toggle_cnt), 32'(tog_exp(m_tog)));
    end
  end

  task automatic cyc(input logic v, input logic co, input logic [7:0] s, input logic r);
    in_valid  = v;
    in_co     = co;
    in_s      = s;
    out_ready = r;
    @(negedge clk);
  endtask

  initial begin
    // Reset with adder output active
    reset_L = 1'b0;
    cyc(1'b1, 1'b0, 8'hFF, 1'b0);
    cyc(1'b1, 1'b0, 8'hFF, 1'b0);
    reset_L = 1'b1;
    in_valid = 1'b0;
    chk("rst_count", 32'(count), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_data", 32'(out_data), 32'h000);
    chk("rst_toggle", 32'(toggle_cnt), 0);

    // Single word
    cyc(1'b1, 1'b1, 8'h3C, 1'b0);
    in_valid = 1'b0;
    chk("single_data", 32'(out_data), 32'h13C);
    chk("single_valid", 32'(out_valid), 1);
    chk("single_count", 32'(count), 1);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    out_ready = 1'b0;
    chk("single_pop_valid", 32'(out_valid), 0);
    chk("single_pop_count", 32'(count), 0);
    chk("single_hold_data", 32'(out_data), 32'h13C);

    // Fill and overflow
    for (int i = 1; i <= 5; i++) begin
      cyc(1'b1, 1'b0, 8'(i), 1'b0);
      if (i == 4) chk("full_in_ready", 32'(in_ready), 0);
    end
    chk("full_count", 32'(count), 4);
    for (int k = 1; k <= 4; k++) begin
      chk("drain_order", 32'(out_data), 32'(k));
      cyc(1'b0, 1'b0, 8'h00, 1'b1);
    end
    chk("drain_count", 32'(count), 0);

    // Simultaneous push/pop at count=2
    cyc(1'b1, 1'b0, 8'h10, 1'b0);
    cyc(1'b1, 1'b0, 8'h11, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 1'b0, 8'(8'h12 + i), 1'b1);
      chk("pp_count", 32'(count), 2);
    end
    chk("pp_head0", 32'(out_data), 32'h01A);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    chk("pp_head1", 32'(out_data), 32'h01B);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);

    // Mid-operation reset
    cyc(1'b1, 1'b0, 8'hA0, 1'b0);
    cyc(1'b1, 1'b0, 8'hA1, 1'b0);
    cyc(1'b1, 1'b0, 8'hA2, 1'b0);
    chk("mid_pre_count", 32'(count), 3);
    reset_L = 1'b0;
    cyc(1'b1, 1'b0, 8'hEE, 1'b1);
    reset_L = 1'b1;
    chk("mid_count", 32'(count), 0);
    chk("mid_valid", 32'(out_valid), 0);
    chk("mid_data", 32'(out_data), 0);
    cyc(1'b1, 1'b0, 8'hB0, 1'b0);
    cyc(1'b1, 1'b0, 8'hB1, 1'b0);
    chk("mid_first", 32'(out_data), 32'h0B0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    chk("mid_second", 32'(out_data), 32'h0B1);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);

    // Toggle accounting (saturating at 15 with TCW=4)
    reset_L = 1'b0;
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    reset_L = 1'b1;
    cyc(1'b1, 1'b0, 8'h00, 1'b1);
    chk("tog_000", 32'(toggle_cnt), 32'(tog_exp(0)));
    cyc(1'b1, 1'b1, 8'hFF, 1'b1);
    chk("tog_1ff", 32'(toggle_cnt), 32'(tog_exp(9)));
    cyc(1'b1, 1'b0, 8'hF0, 1'b1);
    chk("tog_0f0", 32'(toggle_cnt), 32'(tog_exp(14)));
    cyc(1'b1, 1'b0, 8'hF0, 1'b1);
    chk("tog_0f0_again", 32'(toggle_cnt), 32'(tog_exp(14)));
    cyc(1'b1, 1'b1, 8'hFF, 1'b1);
    chk("tog_sat", 32'(toggle_cnt), 32'(tog_exp(15)));
    cyc(1'b1, 1'b0, 8'h00, 1'b1);
    chk("tog_sat_hold", 32'(toggle_cnt), 32'(tog_exp(15)));
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    chk("tog_idle", 32'(toggle_cnt), 32'(tog_exp(15)));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
